// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch front end.
//
// Walks the PC sequentially, issuing one read per cycle to an instruction
// memory with a fixed 1-cycle read latency. Returned words go into a small
// in-order fetch queue that is presented to decode with a valid/ready
// handshake. An all-zero instruction word ends the program: fetch stops,
// the queue drains, and done is raised and held until reset.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active high
//   imem_req     read request this cycle
//   imem_addr    byte address of the request (current PC)
//   imem_rdata   read data, valid the cycle after imem_req
//   instr_out    instruction at the queue head
//   pc_out       PC of instr_out
//   instr_valid  queue head is valid
//   instr_ready  decode accepts the head this cycle
//   queue_count  current queue occupancy
//   done         program terminated and fully drained
module fetch_unit #(
  parameter int          INSTR_WIDTH = 32,
  parameter int          ADDR_WIDTH  = 32,
  parameter int unsigned PC_RESET    = 0,
  parameter int          QUEUE_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           imem_req,
  output logic [ADDR_WIDTH-1:0]          imem_addr,
  input  logic [INSTR_WIDTH-1:0]         imem_rdata,
  output logic [INSTR_WIDTH-1:0]         instr_out,
  output logic [ADDR_WIDTH-1:0]          pc_out,
  output logic                           instr_valid,
  input  logic                           instr_ready,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count,
  output logic                           done
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {FETCH, DRAIN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   pc_reg;
  logic [ADDR_WIDTH-1:0]   req_pc_reg;
  logic                    inflight_reg;
  logic [CW-1:0]           count_reg;
  logic [PW-1:0]           wr_ptr_reg;
  logic [PW-1:0]           rd_ptr_reg;
  logic                    done_reg;

  logic [INSTR_WIDTH-1:0]  q_instr [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0]   q_pc    [QUEUE_DEPTH];

  logic credit_ok;
  logic resp_valid;
  logic is_term;
  logic enq;
  logic deq;

  // Credit check counts the outstanding read as occupied; a dequeue in the
  // same cycle deliberately does not free a slot, which keeps the check
  // off the instr_ready path.
  assign credit_ok  = (count_reg + CW'(inflight_reg)) < CW'(QUEUE_DEPTH);
  assign imem_req   = (state_reg == FETCH) && !rst && credit_ok;
  assign imem_addr  = pc_reg;

  // Responses only matter while still fetching; anything arriving in
  // DRAIN or DONE belongs to a cancelled request.
  assign resp_valid = inflight_reg && (state_reg == FETCH);
  assign is_term    = resp_valid && (imem_rdata == '0);
  assign enq        = resp_valid && (imem_rdata != '0);
  assign deq        = instr_valid && instr_ready;

  assign instr_valid = (count_reg != '0);
  assign instr_out   = q_instr[rd_ptr_reg];
  assign pc_out      = q_pc[rd_ptr_reg];
  assign queue_count = count_reg;
  assign done        = done_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FETCH:   if (is_term) state_next = DRAIN;
      DRAIN:   if ((count_reg == '0) && !inflight_reg) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= FETCH;
      pc_reg       <= ADDR_WIDTH'(PC_RESET);
      req_pc_reg   <= ADDR_WIDTH'(PC_RESET);
      inflight_reg <= 1'b0;
      count_reg    <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (imem_req) begin
        pc_reg     <= pc_reg + ADDR_WIDTH'(4);
        req_pc_reg <= pc_reg;
      end
      // A request issued alongside the terminator is cancelled by never
      // marking it in flight; pc is not rewound since fetch is over.
      inflight_reg <= imem_req && !is_term;
      if (enq) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (deq) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
      if ((state_reg == DRAIN) && (state_next == DONE)) done_reg <= 1'b1;
    end
  end

  // Queue storage: no reset needed, occupancy alone decides validity.
  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (enq && (wr_ptr_reg == PW'(gi))) begin
        q_instr[gi] <= imem_rdata;
        q_pc[gi]    <= req_pc_reg;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
//
// A memory model answers requests one cycle later. A transaction-level
// model (expected program-order queue of {pc, instr}, outstanding read,
// next fetch address, terminator/done flags) is checked against the DUT on
// every falling edge. Directed sequences add literal expectations for the
// basic stream, backpressure, reset mid-run, terminator cancel and DONE hold.
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic [2:0]  queue_count;
  logic        done;

  always #5 clk = ~clk;

  fetch_unit #(
    .INSTR_WIDTH(32),
    .ADDR_WIDTH (32),
    .PC_RESET   (0),
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr_out  (instr_out),
    .pc_out     (pc_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .queue_count(queue_count),
    .done       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_deq = 0;
  logic chk_en = 1'b0;
  logic saw_bad = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- instruction memory ----------------
  logic [31:0] mem [64];
  logic        seen_req  = 1'b0;
  logic [31:0] seen_addr = 32'h0;

  task automatic load_default();
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | 32'(i);
  endtask

  always @(negedge clk) begin
    seen_req  = imem_req;
    seen_addr = imem_addr;
  end

  // Data for a request appears in the following cycle; otherwise drive
  // nonzero garbage that the DUT must ignore.
  always @(posedge clk) begin
    #1;
    if (seen_req === 1'b1) imem_rdata = mem[seen_addr[7:2]];
    else                   imem_rdata = 32'hBAD0_0000 | {24'h0, seen_addr[7:0]};
  end

  // ---------------- behavioural model + compare ----------------
  logic [63:0] m_q[$];
  logic        m_out = 1'b0;
  logic [31:0] m_out_addr = 32'h0;
  logic [31:0] m_pc = 32'h0;
  logic        m_term = 1'b0;
  logic        m_done = 1'b0;

  always @(negedge clk) begin
    logic        exp_req;
    logic        got_term;
    logic        done_cond;
    logic [31:0] word;
    exp_req = (rst == 1'b0) && !m_term && ((m_q.size() + int'(m_out)) < DEPTH);
    if (chk_en) begin
      check("imem_req", 64'(imem_req), 64'(exp_req));
      if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_pc));
      check("instr_valid", 64'(instr_valid), 64'(m_q.size() != 0));
      if (m_q.size() != 0) check("head_pc_instr", {pc_out, instr_out}, m_q[0]);
      check("queue_count", 64'(queue_count), 64'(m_q.size()));
      check("no_overflow", 64'(queue_count <= 3'(DEPTH)), 64'(1));
      check("done", 64'(done), 64'(m_done));
      if (instr_valid && instr_out == 32'h0010_0093) saw_bad = 1'b1;
    end
    if (rst) begin
      m_q.delete();
      m_out  = 1'b0;
      m_pc   = 32'h0;
      m_term = 1'b0;
      m_done = 1'b0;
    end else begin
      got_term  = 1'b0;
      done_cond = m_term && (m_q.size() == 0) && !m_out;
      if ((m_q.size() != 0) && instr_ready) begin
        if (chk_en) $display("deq pc=%08h instr=%08h", m_q[0][63:32], m_q[0][31:0]);
        void'(m_q.pop_front());
        n_deq++;
      end
      if (m_out) begin
        word = mem[m_out_addr[7:2]];
        if (word != 32'h0) m_q.push_back({m_out_addr, word});
        else               got_term = 1'b1;
      end
      if (done_cond) m_done = 1'b1;
      m_out      = exp_req && !got_term;
      m_out_addr = m_pc;
      if (exp_req) m_pc = m_pc + 32'd4;
      if (got_term) m_term = 1'b1;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic pulse_reset(input logic ready_val);
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    instr_ready = ready_val;
  endtask

  initial begin
    int start_deq;
    logic finished;
    rst = 1'b1;
    instr_ready = 1'b0;
    imem_rdata = 32'h0;
    load_default();

    // Basic stream: three instructions then a terminator at 0x0C.
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h0020_81B3;
    mem[3] = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    instr_ready = 1'b1;
    chk_en = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      case (c)
        0: begin
          check("bs_c0_req", 64'(imem_req), 64'(1));
          check("bs_c0_addr", 64'(imem_addr), 64'h0);
          check("bs_c0_valid", 64'(instr_valid), 64'(0));
        end
        1: check("bs_c1_addr", 64'(imem_addr), 64'h4);
        2: begin
          check("bs_c2_addr", 64'(imem_addr), 64'h8);
          check("bs_c2_pc", 64'(pc_out), 64'h0);
          check("bs_c2_instr", 64'(instr_out), 64'h0050_0093);
        end
        3: begin
          check("bs_c3_addr", 64'(imem_addr), 64'hC);
          check("bs_c3_instr", 64'(instr_out), 64'h00A0_0113);
        end
        4: begin
          check("bs_c4_addr", 64'(imem_addr), 64'h10);
          check("bs_c4_pc", 64'(pc_out), 64'h8);
          check("bs_c4_instr", 64'(instr_out), 64'h0020_81B3);
        end
        5: begin
          check("bs_c5_valid", 64'(instr_valid), 64'(0));
          check("bs_c5_req", 64'(imem_req), 64'(0));
          check("bs_c5_done", 64'(done), 64'(0));
        end
        default: check("bs_c6_done", 64'(done), 64'(1));
      endcase
    end

    // Backpressure with no terminator, then resume with toggling ready.
    load_default();
    pulse_reset(1'b0);
    for (int c = 0; c < 6; c++) @(negedge clk);
    check("bp_count_full", 64'(queue_count), 64'(4));
    check("bp_req_stalled", 64'(imem_req), 64'(0));
    check("bp_head_pc", 64'(pc_out), 64'h0);
    @(posedge clk); #2;
    instr_ready = 1'b1;
    @(negedge clk);
    check("bp_c6_head_pc", 64'(pc_out), 64'h0);
    check("bp_c6_req", 64'(imem_req), 64'(0));
    @(negedge clk);
    check("bp_c7_req", 64'(imem_req), 64'(1));
    check("bp_c7_addr", 64'(imem_addr), 64'h10);
    check("bp_c7_pc", 64'(pc_out), 64'h4);
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #2;
      instr_ready = (i % 3) != 1;
    end

    // Reset mid-run with queue_count=3 and a read in flight.
    pulse_reset(1'b0);
    for (int c = 0; c < 4; c++) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    @(negedge clk);
    check("mr_pre_count", 64'(queue_count), 64'(3));
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid", 64'(instr_valid), 64'(0));
    check("mr_count", 64'(queue_count), 64'(0));
    check("mr_addr", 64'(imem_addr), 64'h0);
    @(negedge clk);
    check("mr_stale_ignored", 64'(queue_count), 64'(0));
    @(negedge clk);
    check("mr_first_entry", 64'(queue_count), 64'(1));

    // Terminator at 0x0C with a live word at 0x10 that must be dropped.
    load_default();
    mem[3] = 32'h0000_0000;
    mem[4] = 32'h0010_0093;
    saw_bad = 1'b0;
    pulse_reset(1'b1);
    start_deq = n_deq;
    finished = 1'b0;
    for (int i = 0; i < 40 && !finished; i++) begin
      @(negedge clk);
      if (done) finished = 1'b1;
      @(posedge clk); #2;
      instr_ready = (i % 3) != 1;
    end
    check("tc_done_reached", 64'(finished), 64'(1));
    check("tc_delivered", 64'(n_deq - start_deq), 64'(3));
    check("tc_cancel_dropped", 64'(saw_bad), 64'(0));

    // DONE hold.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #2;
      instr_ready = i[0];
      @(negedge clk);
      check("dh_done", 64'(done), 64'(1));
      check("dh_req", 64'(imem_req), 64'(0));
      check("dh_valid", 64'(instr_valid), 64'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end that produces the 32-bit instruction stream consumed by the decode/control stage.
- Generates sequential PCs and issues reads to the instruction memory, which has a fixed 1-cycle read latency.
- Buffers returned words in a small in-order fetch queue and presents them with a valid/ready handshake.
- An all-zero instruction word terminates the program: fetch stops, the queue drains, and `done` is raised.

Parameters:
- INSTR_WIDTH, 32, instruction width in bits.
- ADDR_WIDTH, 32, PC / memory byte-address width.
- PC_RESET, 0, PC value loaded on reset.
- QUEUE_DEPTH, 4, fetch queue entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- imem_req  out  1  read request this cycle.
- imem_addr  out  ADDR_WIDTH  byte address of the request; equals the current PC.
- imem_rdata  in  INSTR_WIDTH  read data; valid the cycle after imem_req.
- instr_out  out  INSTR_WIDTH  instruction at the queue head.
- pc_out  out  ADDR_WIDTH  PC of instr_out.
- instr_valid  out  1  queue head is valid.
- instr_ready  in  1  decode accepts the head this cycle.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.
- done  out  1  program terminated and fully drained.

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: pc=PC_RESET, queue empty, queue_count=0, instr_valid=0, inflight=0, done=0, state=FETCH.
  - imem_req is combinationally 0 while rst=1.
  - instr_out and pc_out are don't-care while instr_valid=0.
- States:
  - FETCH -> DRAIN when a terminator response is captured.
  - DRAIN -> DONE when queue_count==0 and inflight==0.
  - DONE stays in DONE until rst.
- Request issue:
  - imem_req = (state==FETCH) && !rst && (queue_count + inflight < QUEUE_DEPTH).
  - This is a conservative credit check: a dequeue in the same cycle does not free a credit.
  - On request: imem_addr=pc; pc <= pc+4, wrapping modulo 2^ADDR_WIDTH; inflight <= 1; req_pc <= pc.
  - With no request, inflight <= 0.
- Response (cycle after a request, inflight==1):
  - If imem_rdata != 0 and state==FETCH: enqueue {imem_rdata, req_pc} at the tail.
  - If imem_rdata == 0: do not enqueue; state <= DRAIN.
  - A request issued in that same cycle is cancelled: its response next cycle is discarded, and pc is not rewound.
  - In DRAIN/DONE, all responses are discarded.
- Output handshake:
  - instr_valid = (queue_count != 0); the head is driven directly from queue storage.
  - Dequeue when instr_valid && instr_ready.
  - instr_out and pc_out stay stable while instr_valid=1 and instr_ready=0.
- Enqueue and dequeue in the same cycle: both happen, queue_count is unchanged, pointers advance, order is preserved.
- Full queue: the credit check guarantees no enqueue arrives when full; an overflow is a design error and the bench asserts on it.
- Latency: request at cycle t, data captured at the end of t+1, instr_valid=1 in cycle t+2.
- Throughput: with instr_ready held at 1, one instruction per cycle in steady state.
- done is registered: asserted in the cycle after the DRAIN->DONE condition holds, and held until rst.
- Reset mid-operation:
  - Queue flushed, inflight cleared.
  - imem_rdata in the cycle after rst deasserts is ignored, since inflight=0.
  - Fetch restarts at PC_RESET.

Test Plan:
- Basic stream:
  - Stimulus: memory 0x00:0x00500093, 0x04:0x00A00113, 0x08:0x002081B3, 0x0C:0x00000000; instr_ready=1; release rst at cycle 0.
  - Response: imem_addr 0,4,8,0xC in cycles 0-3; the request at 0x10 is cancelled; instr_valid cycles 2-4 with pc_out 0,4,8 and matching instr_out; done=1 at cycle 6.
- Backpressure:
  - Stimulus: instr_ready=0, QUEUE_DEPTH=4, no terminator.
  - Response: exactly 4 requests (0,4,8,0xC), queue_count=4, imem_req=0, instr_out stable at PC 0.
  - Then raise instr_ready: requests resume at 0x10; pc_out sequence 0,4,8,0xC,0x10 in order.
- Simultaneous enqueue/dequeue:
  - Stimulus: steady state, instr_ready toggling 1,0,1.
  - Response: queue_count never exceeds 4, no dropped or duplicated PCs, and enqueue+dequeue cycles leave the count unchanged.
- Terminator with cancelled request:
  - Stimulus: 0x0C=0, 0x10=0x00100093.
  - Response: the 0x10 response is discarded, 0x00100093 never appears on instr_out, and state holds DRAIN until the queue empties.
- Reset mid-run:
  - Stimulus: queue_count=3 with inflight=1; assert rst for 1 cycle.
  - Response: next cycle instr_valid=0, queue_count=0; first post-reset imem_addr=PC_RESET; stale imem_rdata ignored.
- DONE hold:
  - Stimulus: after done=1, drive nonzero imem_rdata and toggle instr_ready for 10 cycles.
  - Response: imem_req=0, instr_valid=0, done=1 throughout.
